// File: rtl/polybius_encrypt_stream.sv
// Streaming 7x7 Polybius encryptor: one plaintext byte in, two ASCII coordinate digits out (row, then column).
// Also keeps a wrapping count of emitted characters and a sticky flag for out-of-range input.
module polybius_encrypt_stream #(
  parameter int          GRID       = 7,
  parameter logic [7:0]  BASE_CHAR  = 8'h2A,
  parameter logic [7:0]  DIGIT_BASE = 8'h31,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             invalid_seen,
  output logic [CNT_W-1:0] char_count,
  input  logic             clear
);

  // Handshake: a byte moves on either side only in a cycle where valid and ready are both high;
  // a producer holding valid keeps its data stable until that cycle.
  typedef enum logic [1:0] {IDLE, ROW, COL} state_t;

  localparam logic [7:0] CELLS = 8'(GRID * GRID);
  localparam logic [7:0] BAD_DIGIT = 8'h30;

  state_t           state, state_n;
  logic [7:0]       row_q, col_q, row_n, col_n;
  logic [7:0]       out_byte_n;
  logic             out_valid_n, out_last_n, invalid_n;
  logic [CNT_W-1:0] count_n;

  logic [7:0]       idx, rem, row_idx;
  logic             in_range;
  logic [7:0]       cap_row, cap_col;
  logic             capture, count_inc;

  // Row index from a compare/subtract chain against constant multiples of GRID.
  always_comb begin
    idx      = in_char - BASE_CHAR;
    in_range = (in_char >= BASE_CHAR) && (idx < CELLS);
    row_idx  = '0;
    rem      = idx;
    for (int r = 1; r < GRID; r++) begin
      if (idx >= 8'(r * GRID)) begin
        row_idx = 8'(r);
        rem     = idx - 8'(r * GRID);
      end
    end
    cap_row = in_range ? (DIGIT_BASE + row_idx) : BAD_DIGIT;
    cap_col = in_range ? (DIGIT_BASE + rem)     : BAD_DIGIT;
  end

  assign in_ready = (state == IDLE) || ((state == COL) && out_ready);
  assign capture  = in_valid && in_ready;

  always_comb begin
    state_n     = state;
    row_n       = row_q;
    col_n       = col_q;
    out_byte_n  = out_byte;
    out_valid_n = out_valid;
    out_last_n  = out_last;
    count_inc   = 1'b0;
    case (state)
      IDLE: begin
        out_valid_n = 1'b0;
      end
      ROW: begin
        if (out_ready) begin
          out_byte_n = col_q;
          out_last_n = 1'b1;
          state_n    = COL;
        end
      end
      COL: begin
        if (out_ready) begin
          count_inc   = 1'b1;
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
          state_n     = IDLE;
        end
      end
      default: begin
        out_valid_n = 1'b0;
        out_last_n  = 1'b0;
        state_n     = IDLE;
      end
    endcase
    // A capture in IDLE or on the closing COL beat overrides the return to IDLE.
    if (capture) begin
      row_n       = cap_row;
      col_n       = cap_col;
      out_byte_n  = cap_row;
      out_valid_n = 1'b1;
      out_last_n  = 1'b0;
      state_n     = ROW;
    end
    invalid_n = clear ? 1'b0 : invalid_seen;
    if (capture && !in_range) invalid_n = 1'b1;
    count_n = clear ? '0 : (count_inc ? char_count + {{(CNT_W-1){1'b0}}, 1'b1} : char_count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      out_byte     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      invalid_seen <= 1'b0;
      char_count   <= '0;
    end else begin
      state        <= state_n;
      row_q        <= row_n;
      col_q        <= col_n;
      out_byte     <= out_byte_n;
      out_valid    <= out_valid_n;
      out_last     <= out_last_n;
      invalid_seen <= invalid_n;
      char_count   <= count_n;
    end
  end

endmodule

// File: tb/tb_polybius_encrypt_stream.sv
// Directed bench for polybius_encrypt_stream: hand-computed digit pairs, an expected-beat queue,
// a hold-stability monitor under backpressure and a mid-flight reset.
module tb_polybius_encrypt_stream;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_char = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_byte;
  logic             out_last;
  logic             invalid_seen;
  logic [CNT_W-1:0] char_count;
  logic             clear = 1'b0;

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] exp_q[$];
  bit         bp_en = 1'b0;
  logic [8:0] hold_val = '0;
  bit         hold_pending = 1'b0;

  polybius_encrypt_stream #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
    .invalid_seen(invalid_seen), .char_count(char_count), .clear(clear)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: beats as {out_last, out_byte}, sampled mid-cycle before the accepting edge
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("hold_stable", {23'd0, out_last, out_byte}, {23'd0, hold_val});
      hold_pending = out_valid && !out_ready;
      hold_val     = {out_last, out_byte};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 32'(exp_q.size()), 32'd1);
        else check("beat", {23'd0, out_last, out_byte}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // random out_ready at about 30% duty when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = ($urandom_range(0, 9) < 3);
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] ch, input logic [7:0] rd, input logic [7:0] cd, output int waited);
    bit acc;
    exp_q.push_back({1'b0, rd});
    exp_q.push_back({1'b1, cd});
    in_valid = 1'b1;
    in_char  = ch;
    waited   = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        waited = n;
        break;
      end
    end
    if (waited < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_char  = 8'($urandom_range(0, 255));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 400; n++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    if (n == 400) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] bp_chars[8] = '{8'h41, 8'h2A, 8'h5A, 8'h5B, 8'h48, 8'h30, 8'h45, 8'h29};
  logic [7:0] bp_rows[8]  = '{8'h34, 8'h31, 8'h37, 8'h30, 8'h35, 8'h31, 8'h34, 8'h30};
  logic [7:0] bp_cols[8]  = '{8'h33, 8'h31, 8'h37, 8'h30, 8'h33, 8'h37, 8'h37, 8'h30};

  initial begin
    int w;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'h00);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_invalid", 32'(invalid_seen), 32'd0);
    check("rst_count", 32'(char_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;

    // 'A' = idx 23 -> row 3, col 2 -> "43"
    send(8'h41, 8'h34, 8'h33, w);
    idle();
    check("a_row_valid", 32'(out_valid), 32'd1);
    check("a_row_byte", 32'(out_byte), 32'h34);
    check("a_row_last", 32'(out_last), 32'd0);
    tick();
    check("a_col_byte", 32'(out_byte), 32'h33);
    check("a_col_last", 32'(out_last), 32'd1);
    drain();
    check("a_count", 32'(char_count), 32'd1);

    // grid corners: '*' -> "11", '0' -> "17", 'Z' -> "77"
    send(8'h2A, 8'h31, 8'h31, w); idle(); drain();
    send(8'h30, 8'h31, 8'h37, w); idle(); drain();
    send(8'h5A, 8'h37, 8'h37, w); idle(); drain();
    check("corner_count", 32'(char_count), 32'd4);
    check("corner_invalid", 32'(invalid_seen), 32'd0);

    // just outside the grid on both sides -> "00"
    send(8'h5B, 8'h30, 8'h30, w); idle(); drain();
    send(8'h29, 8'h30, 8'h30, w); idle(); drain();
    check("bad_invalid", 32'(invalid_seen), 32'd1);
    check("bad_count", 32'(char_count), 32'd6);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_invalid", 32'(invalid_seen), 32'd0);
    check("clear_count", 32'(char_count), 32'd0);

    // clear on the same edge as the count increment: clear wins
    out_ready = 1'b0;
    send(8'h41, 8'h34, 8'h33, w); idle();
    out_ready = 1'b1;
    tick();
    check("cw_col_last", 32'(out_last), 32'd1);
    out_ready = 1'b0;
    tick();
    clear = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    check("cw_count", 32'(char_count), 32'd0);
    check("cw_idle", 32'(out_valid), 32'd0);

    // clear on the same edge as an invalid capture: flag ends set
    clear = 1'b1;
    send(8'h5B, 8'h30, 8'h30, w);
    clear = 1'b0;
    idle();
    check("ci_invalid", 32'(invalid_seen), 32'd1);
    drain();
    check("ci_count", 32'(char_count), 32'd1);

    // HELLO back-to-back: H=53 E=47 L=57 L=57 O=63, one char every two cycles
    out_ready = 1'b1;
    send(8'h48, 8'h35, 8'h33, w); check("hello_h_wait", 32'(w), 32'd0);
    send(8'h45, 8'h34, 8'h37, w); check("hello_e_wait", 32'(w), 32'd1);
    send(8'h4C, 8'h35, 8'h37, w); check("hello_l_wait", 32'(w), 32'd1);
    send(8'h4C, 8'h35, 8'h37, w); check("hello_l2_wait", 32'(w), 32'd1);
    send(8'h4F, 8'h36, 8'h33, w); check("hello_o_wait", 32'(w), 32'd1);
    idle();
    drain();
    check("hello_count", 32'(char_count), 32'd6);

    // random backpressure with idle gaps
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(bp_chars[i], bp_rows[i], bp_cols[i], w);
      idle();
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    bp_en = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_count", 32'(char_count), 32'd14);

    // reset while the row beat of 'Z' is stalled
    out_ready = 1'b0;
    send(8'h5A, 8'h37, 8'h37, w);
    idle();
    check("mid_row_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_byte", 32'(out_byte), 32'h00);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_count", 32'(char_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(8'h2A, 8'h31, 8'h31, w);
    idle();
    drain();
    check("post_rst_count", 32'(char_count), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
